// File: rtl/flash_boot_loader.sv
// Boot-time copy engine: streams the flash ROM image into instruction memory and holds the core in reset until it is done.
// Optional running checksum of the copied image is enabled with `define FLASH_BOOT_CHECKSUM_EN.
module flash_boot_loader #(
  parameter int ROM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int BOOT_LENGTH    = 1024
) (
  input  logic                      clk,
  input  logic                      sync_rst,
  input  logic                      BootStart,
  output logic [ROM_ADDR_WIDTH-1:0] RomAddress,
  input  logic [DATA_WIDTH-1:0]     RomValue,
  output logic                      IMemWriteValid,
  input  logic                      IMemWriteReady,
  output logic [ROM_ADDR_WIDTH-1:0] IMemWriteAddr,
  output logic [DATA_WIDTH-1:0]     IMemWriteData,
  output logic                      CoreResetHold,
  output logic                      BootBusy,
`ifdef FLASH_BOOT_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]     BootChecksum,
`endif
  output logic                      BootDone
);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  // Last word index; the counter stops here so a full-size image never wraps.
  localparam logic [ROM_ADDR_WIDTH-1:0] LAST_WORD = ROM_ADDR_WIDTH'(BOOT_LENGTH - 1);
  localparam logic [ROM_ADDR_WIDTH-1:0] ONE       = ROM_ADDR_WIDTH'(1);

  state_t                    state, stateNext;
  logic [ROM_ADDR_WIDTH-1:0] count, countNext;
  logic                      transfer;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  always_comb begin
    stateNext      = state;
    countNext      = count;
    transfer       = 1'b0;
    IMemWriteValid = 1'b0;
    CoreResetHold  = 1'b1;
    BootBusy       = 1'b0;
    BootDone       = 1'b0;
    case (state)
      IDLE: begin
        stateNext = COPY;
        countNext = '0;
      end
      COPY: begin
        IMemWriteValid = 1'b1;
        BootBusy       = 1'b1;
        if (IMemWriteReady) begin
          transfer = 1'b1;
          if (count == LAST_WORD) begin
            stateNext = DONE;
          end else begin
            countNext = count + ONE;
          end
        end
      end
      DONE: begin
        BootDone      = 1'b1;
        CoreResetHold = 1'b0;
        if (BootStart) begin
          stateNext = COPY;
          countNext = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        countNext = '0;
      end
    endcase
  end

  assign RomAddress    = count;
  assign IMemWriteAddr = count;
  assign IMemWriteData = RomValue;

`ifdef FLASH_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;

  // Restarted on every entry into COPY so a reload reports only the new image.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      checksum <= '0;
    end else if (state != COPY && stateNext == COPY) begin
      checksum <= '0;
    end else if (transfer) begin
      checksum <= checksum + RomValue;
    end
  end

  assign BootChecksum = checksum;
`endif

endmodule
